// File: rtl/sha256_pkg.sv
// SHA-256 constants, shared types and the round/schedule helper functions.
// Word 0 / H0 sit in the most significant slot of every packed array.
package sha256_pkg;
    localparam int WORD_W  = 32;
    localparam int BLOCK_W = 512;
    localparam int HASH_W  = 256;

    typedef logic [0:7][WORD_W-1:0]  hash_t;
    typedef logic [0:15][WORD_W-1:0] block_t;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    localparam hash_t IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    localparam logic [0:63][WORD_W-1:0] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction
endpackage

// File: rtl/sha256_round_logic.sv
// One combinational SHA-256 round: working variables a..h (slot 0 = a) in, next a..h out.
module sha256_round_logic
    import sha256_pkg::*;
(
    input  hash_t       st_i,
    input  logic [31:0] k_i,
    input  logic [31:0] w_i,
    output hash_t       st_o
);
    logic [31:0] t1;
    logic [31:0] t2;

    always_comb begin
        t1   = st_i[7] + big_sigma1(st_i[4]) + ch(st_i[4], st_i[5], st_i[6]) + k_i + w_i;
        t2   = big_sigma0(st_i[0]) + maj(st_i[0], st_i[1], st_i[2]);
        st_o = {t1 + t2, st_i[0], st_i[1], st_i[2], st_i[3] + t1, st_i[4], st_i[5], st_i[6]};
    end
endmodule

// File: rtl/sha256_core_iter.sv
// Iterative SHA-256 compression core: UNROLL rounds per clock, then one edge
// for the chaining-value add, result held until the consumer takes it.
module sha256_core_iter
    import sha256_pkg::*;
#(
    parameter int UNROLL = 1,
    parameter int TAG_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [511:0]       in_block,
    input  logic [255:0]       in_prev_hash,
    input  logic               in_init_iv,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [255:0]       out_hash,
    output logic [TAG_W-1:0]   out_tag
);
    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8)) begin : g_bad_unroll
        $error("sha256_core_iter: UNROLL must be 1, 2, 4 or 8");
    end

    state_t           state_q, state_d;
    logic [5:0]       rnd_q, rnd_d;
    logic             fin_q, fin_d;
    hash_t            chain_q, chain_d;
    hash_t            st_q, st_d;
    hash_t            out_hash_q, out_hash_d;
    block_t           w_q, w_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    hash_t            rounds_out;

    // Slide the schedule window forward by UNROLL words; words past round 63 are never used.
    function automatic block_t next_window(input block_t w);
        logic [31:0] x [0:15+UNROLL];
        block_t      r;
        for (int i = 0; i < 16; i++) x[i] = w[i];
        for (int i = 16; i < 16 + UNROLL; i++)
            x[i] = small_sigma1(x[i-2]) + x[i-7] + small_sigma0(x[i-15]) + x[i-16];
        for (int i = 0; i < 16; i++) r[i] = x[i+UNROLL];
        return r;
    endfunction

    for (genvar j = 0; j < UNROLL; j++) begin : g_rnd
        hash_t st_in;
        hash_t st_out;
        if (j == 0) begin : g_first
            assign st_in = st_q;
        end else begin : g_next
            assign st_in = g_rnd[j-1].st_out;
        end
        sha256_round_logic u_round (
            .st_i (st_in),
            .k_i  (K[rnd_q + 6'(j)]),
            .w_i  (w_q[j]),
            .st_o (st_out)
        );
    end
    assign rounds_out = g_rnd[UNROLL-1].st_out;

    assign in_ready  = (state_q == ST_IDLE) && !rst;
    assign out_valid = (state_q == ST_DONE);
    assign out_hash  = out_hash_q;
    assign out_tag   = tag_q;

    always_comb begin
        state_d    = state_q;
        rnd_d      = rnd_q;
        fin_d      = fin_q;
        chain_d    = chain_q;
        st_d       = st_q;
        w_d        = w_q;
        tag_d      = tag_q;
        out_hash_d = out_hash_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    chain_d = in_init_iv ? IV : hash_t'(in_prev_hash);
                    st_d    = chain_d;
                    w_d     = block_t'(in_block);
                    tag_d   = in_tag;
                    rnd_d   = '0;
                    fin_d   = 1'b0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (fin_q) begin
                    for (int i = 0; i < 8; i++) out_hash_d[i] = chain_q[i] + st_q[i];
                    fin_d   = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    st_d  = rounds_out;
                    w_d   = next_window(w_q);
                    rnd_d = rnd_q + 6'(UNROLL);
                    fin_d = (rnd_q == 6'(64 - UNROLL));
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rnd_q      <= '0;
            fin_q      <= 1'b0;
            chain_q    <= '0;
            st_q       <= '0;
            w_q        <= '0;
            tag_q      <= '0;
            out_hash_q <= '0;
        end else begin
            state_q    <= state_d;
            rnd_q      <= rnd_d;
            fin_q      <= fin_d;
            chain_q    <= chain_d;
            st_q       <= st_d;
            w_q        <= w_d;
            tag_q      <= tag_d;
            out_hash_q <= out_hash_d;
        end
    end
endmodule

// File: tb/tb_sha256_core_iter.sv
// Scoreboard bench: one core per UNROLL value (1,2,4,8), exercised one at a time
// with known FIPS 180-4 digests; a negedge monitor checks hash, tag, latency, stability.
module tb_sha256_core_iter;
    typedef struct {
        logic [255:0] hash;
        logic [7:0]   tag;
        int           acc;
    } exp_t;

    localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_TWO1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                          32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                          32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                          32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] BLK_TWO2  = {480'h0, 32'h000001c0};
    localparam logic [255:0] H_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] H_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] H_MID   = 256'h85e655d6417a17953363376a624cde5c76e09589cac5f811cc4b32c1f20e533a;
    localparam logic [255:0] H_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst       [4];
    logic         in_valid  [4];
    logic         in_ready  [4];
    logic [511:0] in_block  [4];
    logic [255:0] in_prev   [4];
    logic         in_iv     [4];
    logic [7:0]   in_tag    [4];
    logic         out_valid [4];
    logic         out_ready [4];
    logic [255:0] out_hash  [4];
    logic [7:0]   out_tag   [4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        sha256_core_iter #(.UNROLL(1 << g), .TAG_W(8)) u_dut (
            .clk          (clk),
            .rst          (rst[g]),
            .in_valid     (in_valid[g]),
            .in_ready     (in_ready[g]),
            .in_block     (in_block[g]),
            .in_prev_hash (in_prev[g]),
            .in_init_iv   (in_iv[g]),
            .in_tag       (in_tag[g]),
            .out_valid    (out_valid[g]),
            .out_ready    (out_ready[g]),
            .out_hash     (out_hash[g]),
            .out_tag      (out_tag[g])
        );
    end

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   cur      = 0;
    exp_t exp_q[$];
    exp_t cur_e;
    logic vprev = 1'b0;
    logic have  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s unroll=%0d actual=%h required=%h", name, 1 << cur, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s unroll=%0d actual=event required=no_event", name, 1 << cur);
    endtask

    // Monitor: pop on the rising edge of out_valid, then hold-check every valid cycle.
    always @(negedge clk) begin
        if (rst[cur]) begin
            vprev = 1'b0;
            have  = 1'b0;
        end else begin
            if (out_valid[cur] && !vprev) begin
                if (exp_q.size() == 0) fail_now("unexpected_out");
                else begin
                    cur_e = exp_q.pop_front();
                    have  = 1'b1;
                    chk("latency", 256'(cyc - cur_e.acc), 256'(64 / (1 << cur) + 1));
                end
            end
            if (out_valid[cur] && have) begin
                chk("hash", out_hash[cur], cur_e.hash);
                chk("tag", 256'(out_tag[cur]), 256'(cur_e.tag));
            end
            if (out_valid[cur] && out_ready[cur]) have = 1'b0;
            vprev = out_valid[cur];
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [511:0] blk, input logic [255:0] prev, input logic iv,
                         input logic [7:0] tag, input logic [255:0] exph, input bit expect_out);
        exp_t e;
        int   n;
        in_block[cur] = blk;
        in_prev[cur]  = prev;
        in_iv[cur]    = iv;
        in_tag[cur]   = tag;
        in_valid[cur] = 1'b1;
        n = 0;
        while (!in_ready[cur] && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready[cur]) fail_now("accept_timeout");
        else if (expect_out) begin
            e.hash = exph;
            e.tag  = tag;
            e.acc  = cyc + 1;
            exp_q.push_back(e);
        end
        @(negedge clk);
        in_valid[cur] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || have || out_valid[cur]) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) fail_now("drain_timeout");
    endtask

    initial begin
        logic early;
        logic seen;
        exp_t e;
        int   n;
        for (int g = 0; g < 4; g++) begin
            rst[g] = 1'b1; in_valid[g] = 1'b0; out_ready[g] = 1'b1; in_block[g] = '0;
            in_prev[g] = '0; in_iv[g] = 1'b0; in_tag[g] = '0;
        end
        for (int u = 0; u < 4; u++) begin
            @(negedge clk);
            cur = u;
            @(negedge clk);
            @(negedge clk);
            chk("in_ready_in_reset", 256'(in_ready[cur]), 256'(0));
            rst[cur] = 1'b0;
            @(negedge clk);
            chk("in_ready_after_reset", 256'(in_ready[cur]), 256'(1));
            chk("out_valid_after_reset", 256'(out_valid[cur]), 256'(0));
            chk("out_hash_after_reset", out_hash[cur], 256'(0));
            chk("out_tag_after_reset", 256'(out_tag[cur]), 256'(0));

            issue(BLK_EMPTY, '0, 1'b1, 8'h01, H_EMPTY, 1'b1); drain();
            issue(BLK_ABC, '0, 1'b1, 8'h5a, H_ABC, 1'b1); drain();
            // prev_hash garbage must be ignored when init_iv is set
            issue(BLK_TWO1, {8{32'hdeadbeef}}, 1'b1, 8'h11, H_MID, 1'b1); drain();
            issue(BLK_TWO2, H_MID, 1'b0, 8'h22, H_TWO, 1'b1); drain();

            // Backpressure with the next request already waiting.
            out_ready[cur] = 1'b0;
            issue(BLK_ABC, '0, 1'b1, 8'h33, H_ABC, 1'b1);
            in_block[cur] = BLK_EMPTY; in_iv[cur] = 1'b1; in_tag[cur] = 8'h44; in_valid[cur] = 1'b1;
            early = 1'b0;
            n = 0;
            while (!out_valid[cur] && n < 300) begin
                if (in_ready[cur]) early = 1'b1;
                @(negedge clk);
                n++;
            end
            if (!out_valid[cur]) fail_now("done_timeout");
            repeat (20) begin
                if (in_ready[cur]) early = 1'b1;
                @(negedge clk);
            end
            out_ready[cur] = 1'b1;
            chk("in_ready_in_done", 256'(in_ready[cur]), 256'(0));
            @(negedge clk);
            chk("in_ready_after_handshake", 256'(in_ready[cur]), 256'(1));
            chk("no_early_accept", 256'(early), 256'(0));
            e.hash = H_EMPTY; e.tag = 8'h44; e.acc = cyc + 1;
            exp_q.push_back(e);
            @(negedge clk);
            in_valid[cur] = 1'b0;
            drain();

            // Abort mid-RUN, then a clean request.
            issue(BLK_ABC, '0, 1'b1, 8'h77, '0, 1'b0);
            repeat ((64 >> u) / 2) @(negedge clk);
            rst[cur] = 1'b1;
            @(negedge clk);
            rst[cur] = 1'b0;
            seen = 1'b0;
            repeat (80) begin
                @(negedge clk);
                if (out_valid[cur]) seen = 1'b1;
            end
            chk("abort_no_out", 256'(seen), 256'(0));
            issue(BLK_ABC, '0, 1'b1, 8'h5a, H_ABC, 1'b1); drain();
            chk("queue_empty", 256'(exp_q.size()), 256'(0));
            rst[cur] = 1'b1;
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sha256_core_iter.md
SHA256_CORE_ITER -- requirements
Module: sha256_core_iter

Interface
REQ-001 SHALL have parameter UNROLL, default 1: rounds per clock; legal values 1, 2, 4, 8; any other value is an elaboration error.
REQ-002 SHALL have parameter TAG_W, default 8: width of the opaque request tag.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  core can accept a request.
REQ-007 in_block  input  512  padded message block; word 0 in bits [511:480].
REQ-008 in_prev_hash  input  256  chaining value; H0 in bits [255:224].
REQ-009 in_init_iv  input  1  1 = use the FIPS 180-4 initial value and ignore in_prev_hash.
REQ-010 in_tag  input  TAG_W  returned unchanged with the result.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 out_hash  output  256  chaining value + compressed state; H0 in bits [255:224].
REQ-014 out_tag  output  TAG_W  tag of the request that produced out_hash.

Function
REQ-015 FSM states: IDLE, RUN, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-016 IDLE -> RUN on in_valid && in_ready; on that edge the core latches block, tag, and chaining value (IV or in_prev_hash), and loads a..h from the chaining value.
REQ-017 RUN: each cycle performs UNROLL consecutive SHA-256 rounds; round counter advances by UNROLL, from 0 to 64-UNROLL.
REQ-018 Message schedule: rolling 16-word window; W[t] = block word t for t<16; otherwise sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16], all mod 2^32.
REQ-019 After the last round cycle, one extra edge performs per-word mod-2^32 addition of the chaining value and a..h into out_hash, then enters DONE.
REQ-020 Latency: out_valid rises exactly 64/UNROLL + 1 edges after the accepting edge (65 for UNROLL=1, 9 for UNROLL=8).
REQ-021 DONE: out_hash and out_tag are held stable until out_valid && out_ready; then DONE -> IDLE on that edge.
REQ-022 Minimum request spacing: 64/UNROLL + 3 cycles with out_ready tied high.
REQ-023 In DONE, in_valid is not accepted even if out_ready is high in the same cycle; the request waits for IDLE.
REQ-024 in_valid while in RUN or DONE has no effect; the requester holds its data until in_ready.
REQ-025 out_hash and out_tag are don't-care when out_valid = 0, but they SHALL NOT change while out_valid = 1.

Reset
REQ-026 rst high at an edge forces IDLE, out_valid = 0, out_hash = 0, out_tag = 0, and round counter = 0.
REQ-027 in_ready SHALL be 0 while rst is high and 1 in the first cycle after rst is released.
REQ-028 rst during RUN or DONE aborts the operation; no out_valid is produced for the aborted request.

Structure
REQ-029 Package sha256_pkg SHALL hold the K table (64 x 32-bit), the initial value H0..H7, WORD/BLOCK/HASH width constants, and functions Ch, Maj, Sigma0, Sigma1, sigma0, sigma1.
REQ-030 Sub-module sha256_round_logic SHALL implement one purely combinational round (a..h, K, W -> a..h); the core SHALL chain UNROLL instances of it per cycle.

Verification
REQ-031 init_iv=1, block 0x80000000 followed by fifteen 0 words -> out_hash e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
REQ-032 init_iv=1, "abc" block (0x61626380, fourteen 0 words, 0x00000018), tag 0x5A -> out_hash ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, out_tag 0x5A, latency per REQ-020.
REQ-033 Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq": block 1 with init_iv=1, block 2 with init_iv=0 and prev_hash = block-1 result -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
REQ-034 Backpressure: out_ready low for 20 cycles in DONE -> out_hash and out_tag stable; in_valid held high is not accepted until the cycle after the output handshake.
REQ-035 rst pulse mid-RUN -> out_valid never asserts for that request; the next "abc" request produces the correct digest.
REQ-036 Run REQ-031 to REQ-035 for UNROLL = 1, 2, 4, 8 -> identical digests, with latencies 65, 33, 17, 9.
